// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates the single register-file write port between the execution
//   pipeline writeback and asynchronous quantum measurement results.
//   Measurements are buffered in a small FIFO. The FIFO head wins the port
//   when the pipe is idle, the FIFO is full, the head has waited
//   STARVE_LIMIT cycles, or the head targets the same rd as the pipe. The
//   same-rd rule keeps the two writes in program order.
//   All write-port outputs are registered, so the write appears one cycle
//   after the grant.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i_pipe_valid/src/rd        pipeline writeback request
//   i_from_*                   pipeline data candidates (64b)
//   o_pipe_stall               pipe must hold its writeback inputs
//   i_meas_valid/rd/data       measurement offer
//   o_meas_ready               measurement accept (FIFO not full)
//   o_wb_en/addr/sel/data      registered regfile write port
module regfile_wb_arbiter #(
    parameter int MEAS_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_pipe_valid,
    input  logic [2:0]  i_pipe_src,
    input  logic [4:0]  i_pipe_rd,
    input  logic [63:0] i_from_data_mem,
    input  logic [63:0] i_from_alu,
    input  logic [63:0] i_from_comp_flg,
    input  logic [63:0] i_from_imm,
    output logic        o_pipe_stall,
    input  logic        i_meas_valid,
    input  logic [4:0]  i_meas_rd,
    input  logic [63:0] i_meas_data,
    output logic        o_meas_ready,
    output logic        o_wb_en,
    output logic [4:0]  o_wb_addr,
    output logic [2:0]  o_wb_sel,
    output logic [63:0] o_wb_data
);
    localparam logic [2:0] REGSRC_MEM  = 3'd0;
    localparam logic [2:0] REGSRC_ALU  = 3'd1;
    localparam logic [2:0] REGSRC_COMP = 3'd2;
    localparam logic [2:0] REGSRC_IMM  = 3'd3;
    localparam logic [2:0] REGSRC_MEA  = 3'd4;

    localparam int PW = (MEAS_DEPTH > 1) ? $clog2(MEAS_DEPTH) : 1;
    localparam int CW = $clog2(MEAS_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    r_fifo_rd   [MEAS_DEPTH];
    logic [63:0]   r_fifo_data [MEAS_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;

    logic        w_empty, w_full, w_push, w_meas_grant, w_pipe_grant;
    logic [4:0]  w_head_rd;
    logic [63:0] w_head_data;
    logic [63:0] w_pipe_data;
    logic [2:0]  w_pipe_sel;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(MEAS_DEPTH));
    assign w_head_rd   = r_fifo_rd[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];

    // Full blocks a push even when the head pops this same cycle.
    assign o_meas_ready = !w_full;
    assign w_push       = i_meas_valid && !w_full;

    assign w_meas_grant = !w_empty && (!i_pipe_valid || w_full ||
                          (r_starve == SW'(STARVE_LIMIT)) || (w_head_rd == i_pipe_rd));
    assign w_pipe_grant = i_pipe_valid && !w_meas_grant;
    assign o_pipe_stall = i_pipe_valid && w_meas_grant;

    // Unknown source codes (including MEA) fall back to the ALU result.
    always_comb begin
        w_pipe_data = i_from_alu;
        w_pipe_sel  = REGSRC_ALU;
        case (i_pipe_src)
            REGSRC_MEM:  begin w_pipe_data = i_from_data_mem; w_pipe_sel = REGSRC_MEM;  end
            REGSRC_COMP: begin w_pipe_data = i_from_comp_flg; w_pipe_sel = REGSRC_COMP; end
            REGSRC_IMM:  begin w_pipe_data = i_from_imm;      w_pipe_sel = REGSRC_IMM;  end
            default:     begin w_pipe_data = i_from_alu;      w_pipe_sel = REGSRC_ALU;  end
        endcase
    end

    // FIFO storage: no reset needed, validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= i_meas_rd;
            r_fifo_data[r_wptr] <= i_meas_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_push)
                r_wptr <= (r_wptr == PW'(MEAS_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            if (w_meas_grant)
                r_rptr <= (r_rptr == PW'(MEAS_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            case ({w_push, w_meas_grant})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_empty || w_meas_grant)
                r_starve <= '0;
            else if (r_starve != SW'(STARVE_LIMIT))
                r_starve <= r_starve + 1'b1;
        end
    end

    // Registered write port; address/select/data hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_wb_en   <= 1'b0;
            o_wb_addr <= '0;
            o_wb_sel  <= '0;
            o_wb_data <= '0;
        end else begin
            o_wb_en <= w_meas_grant || w_pipe_grant;
            if (w_meas_grant) begin
                o_wb_addr <= w_head_rd;
                o_wb_sel  <= REGSRC_MEA;
                o_wb_data <= w_head_data;
            end else if (w_pipe_grant) begin
                o_wb_addr <= i_pipe_rd;
                o_wb_sel  <= w_pipe_sel;
                o_wb_data <= w_pipe_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    localparam logic [2:0] S_MEM = 3'd0, S_ALU = 3'd1, S_COMP = 3'd2, S_IMM = 3'd3, S_MEA = 3'd4;
    localparam logic [63:0] D_MEM = 64'h11, D_ALU = 64'h22, D_COMP = 64'h33, D_IMM = 64'h5A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_pipe_valid = 1'b0;
    logic [2:0]  i_pipe_src = '0;
    logic [4:0]  i_pipe_rd = '0;
    logic [63:0] i_from_data_mem = D_MEM, i_from_alu = D_ALU, i_from_comp_flg = D_COMP, i_from_imm = D_IMM;
    logic        o_pipe_stall;
    logic        i_meas_valid = 1'b0;
    logic [4:0]  i_meas_rd = '0;
    logic [63:0] i_meas_data = '0;
    logic        o_meas_ready;
    logic        o_wb_en;
    logic [4:0]  o_wb_addr;
    logic [2:0]  o_wb_sel;
    logic [63:0] o_wb_data;

    typedef struct { logic en; logic [4:0] addr; logic [2:0] sel; logic [63:0] data; } wr_t;
    wr_t exp_q[$];
    wr_t last;
    int checks = 0, failures = 0;

    regfile_wb_arbiter #(.MEAS_DEPTH(2), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_pipe_valid(i_pipe_valid), .i_pipe_src(i_pipe_src), .i_pipe_rd(i_pipe_rd),
        .i_from_data_mem(i_from_data_mem), .i_from_alu(i_from_alu),
        .i_from_comp_flg(i_from_comp_flg), .i_from_imm(i_from_imm),
        .o_pipe_stall(o_pipe_stall),
        .i_meas_valid(i_meas_valid), .i_meas_rd(i_meas_rd), .i_meas_data(i_meas_data),
        .o_meas_ready(o_meas_ready),
        .o_wb_en(o_wb_en), .o_wb_addr(o_wb_addr), .o_wb_sel(o_wb_sel), .o_wb_data(o_wb_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check combinational outputs, then compare the
    // write produced by this cycle's grant against the scoreboard head.
    // we=0 means no grant expected: addr/sel/data must hold the last write.
    task automatic cyc(input string tag,
                       input logic pv, input logic [2:0] src, input logic [4:0] prd,
                       input logic mv, input logic [4:0] mrd, input logic [63:0] mdata,
                       input logic e_stall, input logic e_ready,
                       input logic we, input logic [4:0] waddr, input logic [2:0] wsel,
                       input logic [63:0] wdata);
        wr_t w, got;
        i_pipe_valid = pv; i_pipe_src = src; i_pipe_rd = prd;
        i_meas_valid = mv; i_meas_rd = mrd; i_meas_data = mdata;
        #1;
        chk({tag, ".stall"}, 64'(o_pipe_stall), 64'(e_stall));
        chk({tag, ".ready"}, 64'(o_meas_ready), 64'(e_ready));
        if (we) begin w.en = 1'b1; w.addr = waddr; w.sel = wsel; w.data = wdata; last = w; end
        else    begin w = last; w.en = 1'b0; end
        exp_q.push_back(w);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        chk({tag, ".en"},   64'(o_wb_en),   64'(got.en));
        chk({tag, ".addr"}, 64'(o_wb_addr), 64'(got.addr));
        chk({tag, ".sel"},  64'(o_wb_sel),  64'(got.sel));
        chk({tag, ".data"}, o_wb_data,      got.data);
    endtask

    initial begin
        last = '{1'b0, 5'd0, 3'd0, 64'd0};
        // reset state
        #12;
        chk("rst.en", 64'(o_wb_en), 64'd0);
        chk("rst.addr", 64'(o_wb_addr), 64'd0);
        chk("rst.sel", 64'(o_wb_sel), 64'd0);
        chk("rst.data", o_wb_data, 64'd0);
        chk("rst.ready", 64'(o_meas_ready), 64'd1);
        chk("rst.stall", 64'(o_pipe_stall), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // pipe only, immediate source
        cyc("pipe_imm", 1, S_IMM, 7, 0, 0, 0, 0, 1, 1, 7, S_IMM, D_IMM);
        cyc("idle", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // idle pipe: measurement drains on the cycle after it lands
        cyc("meas_push", 0, 0, 0, 1, 3, 64'd1, 0, 1, 0, 0, 0, 0);
        cyc("meas_wr", 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, S_MEA, 64'd1);
        cyc("meas_empty", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // source decode, including the ALU fallback codes
        cyc("src_mem", 1, S_MEM, 1, 0, 0, 0, 0, 1, 1, 1, S_MEM, D_MEM);
        cyc("src_comp", 1, S_COMP, 2, 0, 0, 0, 0, 1, 1, 2, S_COMP, D_COMP);
        cyc("src_mea", 1, S_MEA, 4, 0, 0, 0, 0, 1, 1, 4, S_ALU, D_ALU);
        cyc("src_7", 1, 3'd7, 5, 0, 0, 0, 0, 1, 1, 5, S_ALU, D_ALU);
        cyc("src_alu", 1, S_ALU, 6, 0, 0, 0, 0, 1, 1, 6, S_ALU, D_ALU);

        // starvation: 8 pipe writes, then one forced measurement grant
        cyc("starve_push", 0, 0, 0, 1, 20, 64'hABC, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc("starve_pipe", 1, S_IMM, 5'(10 + i), 0, 0, 0, 0, 1, 1, 5'(10 + i), S_IMM, D_IMM);
        cyc("starve_force", 1, S_IMM, 30, 0, 0, 0, 1, 1, 1, 20, S_MEA, 64'hABC);
        cyc("starve_after", 1, S_IMM, 30, 0, 0, 0, 0, 1, 1, 30, S_IMM, D_IMM);

        // full FIFO forces a grant and back-pressures the offer
        cyc("full_a", 1, S_ALU, 1, 1, 21, 64'h21, 0, 1, 1, 1, S_ALU, D_ALU);
        cyc("full_b", 1, S_ALU, 2, 1, 22, 64'h22, 0, 1, 1, 2, S_ALU, D_ALU);
        cyc("full_c", 1, S_ALU, 3, 1, 23, 64'h23, 1, 0, 1, 21, S_MEA, 64'h21);
        cyc("full_d", 1, S_ALU, 3, 1, 23, 64'h23, 0, 1, 1, 3, S_ALU, D_ALU);
        cyc("full_e", 1, S_ALU, 4, 0, 0, 0, 1, 0, 1, 22, S_MEA, 64'h22);
        cyc("full_f", 0, 0, 0, 0, 0, 0, 0, 1, 1, 23, S_MEA, 64'h23);
        cyc("full_g", 1, S_ALU, 4, 0, 0, 0, 0, 1, 1, 4, S_ALU, D_ALU);

        // same-rd hazard: measurement first, then pipe
        cyc("haz_push", 0, 0, 0, 1, 9, 64'h99, 0, 1, 0, 0, 0, 0);
        cyc("haz_meas", 1, S_IMM, 9, 0, 0, 0, 1, 1, 1, 9, S_MEA, 64'h99);
        cyc("haz_pipe", 1, S_IMM, 9, 0, 0, 0, 0, 1, 1, 9, S_IMM, D_IMM);

        // reset with two FIFO entries pending
        cyc("rp_a", 1, S_IMM, 1, 1, 11, 64'h1, 0, 1, 1, 1, S_IMM, D_IMM);
        cyc("rp_b", 1, S_IMM, 2, 1, 12, 64'h2, 0, 1, 1, 2, S_IMM, D_IMM);
        i_pipe_valid = 0; i_meas_valid = 0;
        rst_n = 1'b0;
        #1;
        chk("rp.en", 64'(o_wb_en), 64'd0);
        chk("rp.addr", 64'(o_wb_addr), 64'd0);
        chk("rp.ready", 64'(o_meas_ready), 64'd1);
        chk("rp.stall", 64'(o_pipe_stall), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        last = '{1'b0, 5'd0, 3'd0, 64'd0};
        for (int i = 0; i < 3; i++)
            cyc("rp_after", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
